reg_status_file: RTL

REG_STATUS_FILE -- requirements
Module: reg_status_file

---
 rtl/reg_status_file.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/reg_status_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_status_file
// Purpose  : Architectural register file with rename busy/tag scoreboard,
//            commit bypass and rename checkpoints for branch recovery.
// Revision : 1.0 - initial release
// ============================================================================
module reg_status_file #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAGW  = 4,
    parameter int NRD   = 2,
    parameter int NCKPT = 4,
    localparam int REGW = $clog2(NREG),
    localparam int CKW  = $clog2(NCKPT)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  ren_valid,
    input  logic [REGW-1:0]       ren_rd,
    input  logic [TAGW-1:0]       ren_tag,
    input  logic                  cmt_valid,
    input  logic [REGW-1:0]       cmt_rd,
    input  logic [TAGW-1:0]       cmt_tag,
    input  logic [XLEN-1:0]       cmt_data,
    input  logic [NRD*REGW-1:0]   rs_idx,
    output logic [NRD*XLEN-1:0]   rs_val,
    output logic [NRD-1:0]        rs_busy,
    output logic [NRD*TAGW-1:0]   rs_tag,
    input  logic                  ckpt_save,
    input  logic [CKW-1:0]        ckpt_save_id,
    input  logic                  ckpt_restore,
    input  logic [CKW-1:0]        ckpt_restore_id,
    input  logic [NCKPT-1:0]      ckpt_kill_mask,
    input  logic                  ckpt_free,
    input  logic [CKW-1:0]        ckpt_free_id,
    input  logic                  flush_all,
    output logic [NCKPT-1:0]      ckpt_valid,
    output logic                  ckpt_full,
    output logic                  ckpt_ovf,
    output logic [31:0]           commit_cnt
);

    logic [XLEN-1:0] data_q [NREG];
    logic [XLEN-1:0] data_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [TAGW-1:0] tag_q [NREG];
    logic [TAGW-1:0] tag_d [NREG];

    logic [NREG-1:0] slot_busy_q [NCKPT];
    logic [NREG-1:0] slot_busy_d [NCKPT];
    logic [TAGW-1:0] slot_tag_q  [NCKPT][NREG];
    logic [TAGW-1:0] slot_tag_d  [NCKPT][NREG];
    logic [NCKPT-1:0] slot_valid_q, slot_valid_d;

    logic        ovf_q, ovf_d;
    logic [31:0] cnt_q, cnt_d;

    logic w_cmt;
    logic w_ren;

    assign w_cmt = cmt_valid && (cmt_rd != '0);
    assign w_ren = ren_valid && (ren_rd != '0);

    always_comb begin
        data_d       = data_q;
        busy_d       = busy_q;
        tag_d        = tag_q;
        slot_busy_d  = slot_busy_q;
        slot_tag_d   = slot_tag_q;
        slot_valid_d = slot_valid_q;
        ovf_d        = ovf_q;
        cnt_d        = cnt_q;

        if (cmt_valid) begin
            cnt_d = cnt_q + 32'd1;
        end

        if (w_cmt) begin
            data_d[cmt_rd] = cmt_data;
            if (tag_q[cmt_rd] == cmt_tag) begin
                busy_d[cmt_rd] = 1'b0;
            end
            for (int s = 0; s < NCKPT; s++) begin
                if (slot_valid_q[s] && (slot_tag_q[s][cmt_rd] == cmt_tag)) begin
                    slot_busy_d[s][cmt_rd] = 1'b0;
                end
            end
        end

        // A same-cycle rename of the committed rd re-marks it busy with the new producer.
        if (w_ren) begin
            busy_d[ren_rd] = 1'b1;
            tag_d[ren_rd]  = ren_tag;
        end

        if (flush_all) begin
            busy_d       = '0;
            tag_d        = tag_q;
            slot_valid_d = '0;
        end else if (ckpt_restore) begin
            if (slot_valid_q[ckpt_restore_id]) begin
                busy_d = slot_busy_d[ckpt_restore_id];
                tag_d  = slot_tag_q[ckpt_restore_id];
            end else begin
                busy_d = '0;
                tag_d  = tag_q;
            end
            slot_valid_d                  = slot_valid_q & ~ckpt_kill_mask;
            slot_valid_d[ckpt_restore_id] = 1'b0;
        end else begin
            if (ckpt_free) begin
                slot_valid_d[ckpt_free_id] = 1'b0;
            end
            if (ckpt_save) begin
                if (slot_valid_q[ckpt_save_id] && !(ckpt_free && (ckpt_free_id == ckpt_save_id))) begin
                    ovf_d = 1'b1;
                end
                slot_busy_d[ckpt_save_id]  = busy_d;
                slot_tag_d[ckpt_save_id]   = tag_d;
                slot_valid_d[ckpt_save_id] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int r = 0; r < NREG; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            busy_q <= '0;
            for (int s = 0; s < NCKPT; s++) begin
                slot_busy_q[s] <= '0;
                for (int r = 0; r < NREG; r++) begin
                    slot_tag_q[s][r] <= '0;
                end
            end
            slot_valid_q <= '0;
            ovf_q        <= 1'b0;
            cnt_q        <= '0;
        end else if (rdy_in) begin
            data_q       <= data_d;
            busy_q       <= busy_d;
            tag_q        <= tag_d;
            slot_busy_q  <= slot_busy_d;
            slot_tag_q   <= slot_tag_d;
            slot_valid_q <= slot_valid_d;
            ovf_q        <= ovf_d;
            cnt_q        <= cnt_d;
        end
    end

    // Source reads: stored state with the in-flight commit forwarded, rename not visible.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [REGW-1:0] w_idx;
        logic [XLEN-1:0] w_val;
        logic            w_busy;
        logic [TAGW-1:0] w_tag;

        assign w_idx = rs_idx[k*REGW +: REGW];

        always_comb begin
            w_val  = data_q[w_idx];
            w_busy = busy_q[w_idx];
            w_tag  = tag_q[w_idx];
            if (w_idx == '0) begin
                w_val  = '0;
                w_busy = 1'b0;
                w_tag  = '0;
            end else if (cmt_valid && (cmt_rd == w_idx)) begin
                w_val = cmt_data;
                if (busy_q[w_idx] && (tag_q[w_idx] == cmt_tag)) begin
                    w_busy = 1'b0;
                end
            end
        end

        assign rs_val[k*XLEN +: XLEN] = w_val;
        assign rs_busy[k]             = w_busy;
        assign rs_tag[k*TAGW +: TAGW] = w_tag;
    end

    assign ckpt_valid = slot_valid_q;
    assign ckpt_full  = &slot_valid_q;
    assign ckpt_ovf   = ovf_q;
    assign commit_cnt = cnt_q;

endmodule
`default_nettype wire
